// File: rtl/icache_pkg.sv
// Shared types and address-split helpers for the 2-way instruction cache controller.
package icache_pkg;

  typedef enum logic [1:0] {IDLE, MISS, FILL} state_e;

  function automatic int calc_off_w(input int words_per_blk);
    return $clog2(words_per_blk) + 2;
  endfunction

  function automatic int calc_idx_w(input int num_sets);
    return $clog2(num_sets);
  endfunction

  function automatic int calc_tag_w(input int addr_w, input int words_per_blk, input int num_sets);
    return addr_w - calc_off_w(words_per_blk) - calc_idx_w(num_sets);
  endfunction

endpackage

// File: rtl/icache_way_array.sv
// One cache way: per-set block data, tag and valid bit with a single read and write port.
module icache_way_array
  import icache_pkg::*;
#(
  parameter int NUM_SETS = 4,
  parameter int IDX_SW   = 2,
  parameter int TAG_W    = 4,
  parameter int BLK_W    = 128
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              clear,
  input  logic [IDX_SW-1:0] rd_idx,
  output logic [TAG_W-1:0]  rd_tag,
  output logic              rd_valid,
  output logic [BLK_W-1:0]  rd_block,
  input  logic              we,
  input  logic [IDX_SW-1:0] wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  logic [BLK_W-1:0]  wr_block
);

  logic [NUM_SETS-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]    tag_q  [NUM_SETS];
  logic [TAG_W-1:0]    tag_d  [NUM_SETS];
  logic [BLK_W-1:0]    data_q [NUM_SETS];
  logic [BLK_W-1:0]    data_d [NUM_SETS];

  assign rd_tag   = tag_q[rd_idx];
  assign rd_valid = valid_q[rd_idx];
  assign rd_block = data_q[rd_idx];

  // A clear on the same edge as a write wins, so a flushed fill leaves the line invalid.
  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (we) begin
      valid_d[wr_idx] = 1'b1;
      tag_d[wr_idx]   = wr_tag;
      data_d[wr_idx]  = wr_block;
    end
    if (clear) valid_d = '0;
  end

  always_ff @(posedge CLK) begin
    if (RESET) valid_q <= '0;
    else       valid_q <= valid_d;
    tag_q  <= tag_d;
    data_q <= data_d;
  end

endmodule

// File: rtl/icache_2way_ctrl.sv
// 2-way set-associative read-only instruction cache controller with per-set LRU,
// zero-latency hits, a clocked IDLE/MISS/FILL miss sequence and a flush input.
module icache_2way_ctrl
  import icache_pkg::*;
#(
  parameter int ADDR_W        = 10,
  parameter int WORD_W        = 32,
  parameter int WORDS_PER_BLK = 4,
  parameter int NUM_SETS      = 4
) (
  input  logic                                         CLK,
  input  logic                                         RESET,
  input  logic                                         cpu_fetch,
  input  logic [ADDR_W-1:0]                            cpu_addr,
  input  logic                                         flush,
  output logic [WORD_W-1:0]                            instr,
  output logic                                         busywait,
  output logic                                         mem_read,
  output logic [ADDR_W-calc_off_w(WORDS_PER_BLK)-1:0]  mem_addr,
  input  logic                                         mem_busywait,
  input  logic [WORD_W*WORDS_PER_BLK-1:0]              mem_rdata
);

  localparam int OFF_W  = calc_off_w(WORDS_PER_BLK);
  localparam int IDX_W  = calc_idx_w(NUM_SETS);
  localparam int TAG_W  = calc_tag_w(ADDR_W, WORDS_PER_BLK, NUM_SETS);
  localparam int IDX_SW = (IDX_W > 0) ? IDX_W : 1;
  localparam int SEL_W  = (WORDS_PER_BLK > 1) ? $clog2(WORDS_PER_BLK) : 1;
  localparam int BLK_W  = WORD_W * WORDS_PER_BLK;
  localparam int MA_W   = ADDR_W - OFF_W;

  logic [IDX_SW-1:0] idx;
  logic [SEL_W-1:0]  word_sel;
  logic [TAG_W-1:0]  addr_tag;
  logic              unused_byte_bits;

  assign addr_tag         = cpu_addr[ADDR_W-1 -: TAG_W];
  assign unused_byte_bits = ^cpu_addr[1:0];

  if (IDX_W > 0) begin : g_idx
    assign idx = cpu_addr[OFF_W +: IDX_W];
  end else begin : g_no_idx
    assign idx = '0;
  end

  if (WORDS_PER_BLK > 1) begin : g_sel
    assign word_sel = cpu_addr[2 +: SEL_W];
  end else begin : g_no_sel
    assign word_sel = '0;
  end

  logic [TAG_W-1:0]    tag_rd [2];
  logic [BLK_W-1:0]    blk_rd [2];
  logic [1:0]          valid_rd, hit_way, way_we;
  logic                hit, clear_all;
  state_e              state_q, state_d;
  logic                victim_q, victim_d;
  logic [NUM_SETS-1:0] lru_q, lru_d;
  logic                flush_pend_q, flush_pend_d;
  logic                mem_read_q, mem_read_d;
  logic [MA_W-1:0]     mem_addr_q, mem_addr_d;
  logic [BLK_W-1:0]    fill_blk_q, fill_blk_d;

  for (genvar w = 0; w < 2; w++) begin : g_way
    icache_way_array #(
      .NUM_SETS(NUM_SETS), .IDX_SW(IDX_SW), .TAG_W(TAG_W), .BLK_W(BLK_W)
    ) u_way (
      .CLK(CLK), .RESET(RESET), .clear(clear_all),
      .rd_idx(idx), .rd_tag(tag_rd[w]), .rd_valid(valid_rd[w]), .rd_block(blk_rd[w]),
      .we(way_we[w]), .wr_idx(idx), .wr_tag(addr_tag), .wr_block(fill_blk_q)
    );
    assign hit_way[w] = valid_rd[w] && (tag_rd[w] == addr_tag);
  end

  assign hit      = |hit_way;
  assign busywait = cpu_fetch && (RESET || !(state_q == IDLE && hit));
  assign mem_read = mem_read_q;
  assign mem_addr = mem_addr_q;

  always_comb begin
    instr = '0;
    if (hit_way[0])      instr = blk_rd[0][word_sel*WORD_W +: WORD_W];
    else if (hit_way[1]) instr = blk_rd[1][word_sel*WORD_W +: WORD_W];
  end

  // The address is not rechecked in MISS/FILL: the CPU holds it stable while stalled.
  always_comb begin
    state_d      = state_q;
    victim_d     = victim_q;
    lru_d        = lru_q;
    flush_pend_d = flush_pend_q;
    mem_read_d   = mem_read_q;
    mem_addr_d   = mem_addr_q;
    fill_blk_d   = fill_blk_q;
    way_we       = '0;
    clear_all    = 1'b0;
    case (state_q)
      IDLE: begin
        clear_all = flush;
        if (cpu_fetch && hit) begin
          lru_d[idx] = hit_way[0];
        end else if (cpu_fetch) begin
          state_d    = MISS;
          mem_read_d = 1'b1;
          mem_addr_d = cpu_addr[ADDR_W-1:OFF_W];
          victim_d   = !valid_rd[0] ? 1'b0 : (!valid_rd[1] ? 1'b1 : lru_q[idx]);
        end
      end
      MISS: begin
        flush_pend_d = flush_pend_q | flush;
        if (!mem_busywait) begin
          state_d    = FILL;
          mem_read_d = 1'b0;
          fill_blk_d = mem_rdata;
        end
      end
      FILL: begin
        way_we[victim_q] = !RESET;
        lru_d[idx]       = ~victim_q;
        clear_all        = flush_pend_q | flush;
        flush_pend_d     = 1'b0;
        state_d          = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= IDLE;
      victim_q     <= 1'b0;
      lru_q        <= '0;
      flush_pend_q <= 1'b0;
      mem_read_q   <= 1'b0;
      mem_addr_q   <= '0;
    end else begin
      state_q      <= state_d;
      victim_q     <= victim_d;
      lru_q        <= lru_d;
      flush_pend_q <= flush_pend_d;
      mem_read_q   <= mem_read_d;
      mem_addr_q   <= mem_addr_d;
    end
    fill_blk_q <= fill_blk_d;
  end

endmodule

// File: tb/tb_icache_2way_ctrl.sv
// Randomized scoreboard bench for icache_2way_ctrl against a set/way/LRU reference model.
module tb_icache_2way_ctrl;

  localparam int ADDR_W = 10;
  localparam int WORD_W = 32;
  localparam int WPB    = 4;
  localparam int NSETS  = 4;
  localparam int BLK_W  = WORD_W * WPB;

  logic              CLK = 1'b0;
  logic              RESET = 1'b1;
  logic              cpu_fetch = 1'b0;
  logic              flush = 1'b0;
  logic [ADDR_W-1:0] cpu_addr = '0;
  logic [WORD_W-1:0] instr;
  logic              busywait, mem_read, mem_busywait;
  logic [5:0]        mem_addr;
  logic [BLK_W-1:0]  mem_rdata;

  icache_2way_ctrl #(
    .ADDR_W(ADDR_W), .WORD_W(WORD_W), .WORDS_PER_BLK(WPB), .NUM_SETS(NSETS)
  ) dut (
    .CLK(CLK), .RESET(RESET), .cpu_fetch(cpu_fetch), .cpu_addr(cpu_addr), .flush(flush),
    .instr(instr), .busywait(busywait), .mem_read(mem_read), .mem_addr(mem_addr),
    .mem_busywait(mem_busywait), .mem_rdata(mem_rdata)
  );

  always #5 CLK = ~CLK;

  int compared = 0;
  int mismatched = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Memory: busy for lat-1 cycles of each read burst, data on the lat-th cycle.
  int lat = 5;
  int mem_cnt = 0;
  always @(posedge CLK) mem_cnt <= mem_read ? mem_cnt + 1 : 0;
  assign mem_busywait = mem_read && (mem_cnt < lat - 1);

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input int w);
    logic [15:0] mix;
    mix = (16'(blk) * 16'h9e37) ^ 16'h1234;
    return {4'hC, 2'(w), 4'h0, blk, mix};
  endfunction

  always_comb begin
    for (int w = 0; w < WPB; w++) mem_rdata[w*WORD_W +: WORD_W] = mem_word(mem_addr, w);
  end

  // Reference model: what each set holds, which way is next to go.
  bit         m_valid [NSETS][2];
  logic [3:0] m_tag   [NSETS][2];
  bit         m_lru   [NSETS];
  int         exp_mem_reads = 0;
  int         obs_mem_reads = 0;

  typedef struct {
    logic [31:0] instr;
    int          stall;
  } exp_t;
  exp_t sb[$];

  function automatic void model_flush();
    for (int s = 0; s < NSETS; s++) begin
      m_valid[s][0] = 1'b0;
      m_valid[s][1] = 1'b0;
    end
  endfunction

  function automatic void model_reset();
    model_flush();
    for (int s = 0; s < NSETS; s++) m_lru[s] = 1'b0;
  endfunction

  function automatic int model_lookup(input logic [ADDR_W-1:0] a);
    int s;
    s = int'(a[5:4]);
    for (int w = 0; w < 2; w++) if (m_valid[s][w] && m_tag[s][w] == a[9:6]) return w;
    return -1;
  endfunction

  function automatic int model_victim(input int s);
    if (!m_valid[s][0]) return 0;
    if (!m_valid[s][1]) return 1;
    return m_lru[s] ? 1 : 0;
  endfunction

  function automatic void model_fill(input int s, input int v, input logic [3:0] t);
    m_valid[s][v] = 1'b1;
    m_tag[s][v]   = t;
    m_lru[s]      = (v == 0);
  endfunction

  // mode 0 plain, 1 flush in an idle cycle before, 2 flush with the fetch, 3 flush during the miss
  function automatic int model_access(input logic [ADDR_W-1:0] a, input int mode, input int l, output int reads);
    int s, hw, v, stall;
    s = int'(a[5:4]);
    hw = model_lookup(a);
    reads = 0;
    if (hw >= 0) begin
      m_lru[s] = (hw == 0);
      if (mode == 2) model_flush();
      return 0;
    end
    v = model_victim(s);
    if (mode == 2) model_flush();
    model_fill(s, v, a[9:6]);
    stall = l + 2;
    reads = 1;
    if (mode == 3) begin
      model_flush();
      model_fill(s, model_victim(s), a[9:6]);
      stall += l + 2;
      reads = 2;
    end
    return stall;
  endfunction

  bit driver_timeout = 1'b0;

  task automatic applyStimulus(input logic [ADDR_W-1:0] addr, input int mode_in, input int lat_in);
    int mode, k, reads;
    exp_t e;
    if (driver_timeout) return;
    mode = mode_in;
    if (mode == 1) begin
      @(posedge CLK); #1;
      cpu_fetch = 1'b0;
      flush = 1'b1;
      model_flush();
    end
    if (mode == 3 && model_lookup(addr) >= 0) mode = 0;
    lat = lat_in;
    e.instr = mem_word(addr[9:4], int'(addr[3:2]));
    e.stall = model_access(addr, mode, lat_in, reads);
    exp_mem_reads += reads;
    sb.push_back(e);
    @(posedge CLK); #1;
    cpu_addr  = addr;
    cpu_fetch = 1'b1;
    flush     = (mode == 2);
    k = 0;
    forever begin
      @(negedge CLK);
      if (!busywait) break;
      if (k > 200) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL fetch_timeout: addr 0x%0h still stalled after %0d cycles, expected completion", addr, k);
        driver_timeout = 1'b1;
        break;
      end
      @(posedge CLK); #1;
      k++;
      flush = (mode == 3 && k == 1);
    end
  endtask

  // Monitor: one scoreboard entry per completed fetch.
  int   stall_cnt = 0;
  int   obs_hits = 0;
  int   obs_misses = 0;
  exp_t got;
  always @(negedge CLK) begin
    if (RESET) begin
      stall_cnt = 0;
    end else if (cpu_fetch) begin
      if (busywait) begin
        stall_cnt++;
      end else begin
        if (sb.size() == 0) begin
          compared++;
          mismatched++;
          $display("[TB] FAIL unexpected_fetch: output 0x%0h presented, expected none", instr);
        end else begin
          got = sb.pop_front();
          checkOutput("instr", 64'(instr), 64'(got.instr));
          checkOutput("stall_cycles", 64'(stall_cnt), 64'(got.stall));
        end
        if (stall_cnt == 0) obs_hits++;
        else                obs_misses++;
        stall_cnt = 0;
      end
    end
  end

  logic mem_read_prev = 1'b0;
  always @(negedge CLK) begin
    if (mem_read === 1'b1 && !mem_read_prev) begin
      obs_mem_reads++;
      checkOutput("mem_addr", 64'(mem_addr), 64'(cpu_addr[9:4]));
    end
    mem_read_prev = (mem_read === 1'b1);
  end

  task automatic resetMidMiss(input logic [ADDR_W-1:0] addr);
    @(posedge CLK); #1;
    cpu_fetch = 1'b0;
    flush = 1'b1;
    model_flush();
    @(posedge CLK); #1;
    flush = 1'b0;
    lat = 5;
    cpu_addr = addr;
    cpu_fetch = 1'b1;
    exp_mem_reads++;
    @(posedge CLK); #1;
    @(posedge CLK); #1;
    RESET = 1'b1;
    @(negedge CLK);
    checkOutput("busywait_in_reset", 64'(busywait), 64'd1);
    @(posedge CLK); #1;
    RESET = 1'b0;
    cpu_fetch = 1'b0;
    model_reset();
    @(negedge CLK);
    checkOutput("mem_read_after_reset", 64'(mem_read), 64'd0);
    checkOutput("busywait_after_reset", 64'(busywait), 64'd0);
  endtask

  initial begin
    int h0, m0, r;
    logic [ADDR_W-1:0] a;
    RESET = 1'b1;
    cpu_fetch = 1'b1;
    @(negedge CLK);
    checkOutput("busywait_in_reset", 64'(busywait), 64'd1);
    @(posedge CLK); #1;
    cpu_fetch = 1'b0;
    @(posedge CLK); #1;
    RESET = 1'b0;
    model_reset();
    @(negedge CLK);
    checkOutput("reset_mem_read", 64'(mem_read), 64'd0);
    checkOutput("reset_mem_addr", 64'(mem_addr), 64'd0);
    checkOutput("reset_busywait", 64'(busywait), 64'd0);
    checkOutput("reset_instr", 64'(instr), 64'd0);

    $display("[TB] directed scenarios");
    applyStimulus(10'h000, 0, 5);
    applyStimulus(10'h004, 0, 5);
    applyStimulus(10'h040, 0, 5);
    applyStimulus(10'h000, 0, 5);
    applyStimulus(10'h048, 0, 5);
    applyStimulus(10'h000, 0, 5);
    applyStimulus(10'h080, 0, 5);
    applyStimulus(10'h00C, 0, 5);
    applyStimulus(10'h040, 0, 5);
    applyStimulus(10'h010, 3, 5);
    applyStimulus(10'h014, 0, 5);
    applyStimulus(10'h018, 2, 3);
    applyStimulus(10'h0D0, 2, 2);
    resetMidMiss(10'h020);
    applyStimulus(10'h020, 0, 4);
    applyStimulus(10'h028, 0, 4);

    $display("[TB] sequential sweep");
    for (int pass = 0; pass < 2; pass++) begin
      h0 = obs_hits;
      m0 = obs_misses;
      for (int i = 0; i < 256; i++) applyStimulus(10'(i * 4), (pass == 0 && i == 0) ? 1 : 0, 1);
      checkOutput("sweep_hits", 64'(obs_hits - h0), 64'd192);
      checkOutput("sweep_misses", 64'(obs_misses - m0), 64'd64);
    end

    $display("[TB] random traffic");
    for (int i = 0; i < 300; i++) begin
      a = {4'($urandom_range(0, 2)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
      r = $urandom_range(0, 9);
      applyStimulus(a, (r <= 6) ? 0 : r - 6, $urandom_range(1, 6));
    end

    @(posedge CLK); #1;
    cpu_fetch = 1'b0;
    flush = 1'b0;
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("scoreboard_drained", 64'(sb.size()), 64'd0);
    checkOutput("mem_read_count", 64'(obs_mem_reads), 64'(exp_mem_reads));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

  initial begin
    #2000000;
    mismatched++;
    $display("[TB] FAIL global_timeout: simulation still running, expected finish");
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $fatal(1, "[TB] timeout");
  end

endmodule
